// File: rtl/msdf_to_bin.sv
// MSDF digit-stream sink: accumulates signed digits MSD-first into plus/minus
// vectors, then converts to a two's-complement fixed-point result on an elastic port.
module msdf_to_bin #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       dataInArray,
  input  logic             lastIn,
  input  logic             pValidArray,
  output logic             readyArray,
  output logic [W:0]       dataOutArray,
  output logic [CNT_W-1:0] digitCount,
  output logic             validArray,
  input  logic             nReadyArray
);

  localparam int IDX_W = $clog2(W + 1);

  typedef enum logic [1:0] {ACCUM, CONV, OUT} state_t;

  state_t           stateReg, stateNext;
  logic [W-1:0]     pReg, pNext;
  logic [W-1:0]     mReg, mNext;
  logic [IDX_W-1:0] idxReg, idxNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic [W:0]       dataReg, dataNext;
  logic [CNT_W-1:0] countReg, countNext;
  logic             validReg, validNext;

  logic             inXfer;
  logic [W-1:0]     digitSel;

  // One-hot weight select; all-zero once the index reaches W, so surplus digits drop out.
  for (genvar gi = 0; gi < W; gi++) begin : gSel
    assign digitSel[gi] = (idxReg == IDX_W'(W - 1 - gi));
  end

  assign readyArray   = rstn && (stateReg == ACCUM);
  assign inXfer       = pValidArray && readyArray;
  assign dataOutArray = dataReg;
  assign digitCount   = countReg;
  assign validArray   = validReg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stateReg <= ACCUM;
      pReg     <= '0;
      mReg     <= '0;
      idxReg   <= '0;
      cntReg   <= '0;
      dataReg  <= '0;
      countReg <= '0;
      validReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      pReg     <= pNext;
      mReg     <= mNext;
      idxReg   <= idxNext;
      cntReg   <= cntNext;
      dataReg  <= dataNext;
      countReg <= countNext;
      validReg <= validNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    pNext     = pReg;
    mNext     = mReg;
    idxNext   = idxReg;
    cntNext   = cntReg;
    dataNext  = dataReg;
    countNext = countReg;
    validNext = validReg;

    case (stateReg)
      ACCUM: begin
        if (inXfer) begin
          pNext = pReg | (digitSel & {W{dataInArray[1]}});
          mNext = mReg | (digitSel & {W{dataInArray[0]}});
          if (idxReg != IDX_W'(W)) idxNext = idxReg + 1'b1;
          if (cntReg != {CNT_W{1'b1}}) cntNext = cntReg + 1'b1;
          if (lastIn) stateNext = CONV;
        end
      end
      CONV: begin
        dataNext  = {1'b0, pReg} - {1'b0, mReg};
        countNext = cntReg;
        validNext = 1'b1;
        pNext     = '0;
        mNext     = '0;
        idxNext   = '0;
        cntNext   = '0;
        stateNext = OUT;
      end
      OUT: begin
        if (nReadyArray) begin
          validNext = 1'b0;
          stateNext = ACCUM;
        end
      end
      default: stateNext = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_msdf_to_bin.sv
// Randomized bench for msdf_to_bin: digit streams are scored against an arithmetic
// model of the signed-digit value and the handshake timing.
module tb_msdf_to_bin;

  localparam int W     = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic [1:0]       dataInArray;
  logic             lastIn;
  logic             pValidArray;
  logic             readyArray;
  logic [W:0]       dataOutArray;
  logic [CNT_W-1:0] digitCount;
  logic             validArray;
  logic             nReadyArray;

  int nChecks = 0;
  int nFails  = 0;
  logic [1:0] digs[$];

  always #5 clk = ~clk;

  msdf_to_bin #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .dataInArray(dataInArray), .lastIn(lastIn), .pValidArray(pValidArray),
    .readyArray(readyArray),
    .dataOutArray(dataOutArray), .digitCount(digitCount),
    .validArray(validArray), .nReadyArray(nReadyArray)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Value of the stream in units of 2^-W: digit j weighs 2^(W-j), digits past W ignored.
  function automatic logic [W:0] modelValue();
    int v = 0;
    for (int j = 1; j <= digs.size() && j <= W; j++)
      v += (int'(digs[j-1][1]) - int'(digs[j-1][0])) * (1 << (W - j));
    return v[W:0];
  endfunction

  function automatic logic [CNT_W-1:0] modelCount();
    int n = digs.size();
    int lim = (1 << CNT_W) - 1;
    return (n > lim) ? lim[CNT_W-1:0] : n[CNT_W-1:0];
  endfunction

  // Position convention: tasks start and end just after a rising edge.
  task automatic sendDigit(input logic [1:0] d, input logic last);
    logic r;
    bit   done = 0;
    repeat ($urandom_range(0, 2)) begin
      pValidArray = 1'b0;
      dataInArray = 2'($urandom);
      lastIn      = 1'($urandom);
      @(posedge clk); #1;
    end
    pValidArray = 1'b1;
    dataInArray = d;
    lastIn      = last;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk); r = readyArray;
      @(posedge clk); #1;
      if (r) done = 1;
    end
    if (!done) checkVal("ready_timeout", 32'd0, 32'd1);
    pValidArray = 1'b0;
    dataInArray = 2'($urandom);
    lastIn      = 1'($urandom);
  endtask

  task automatic runStream(input int stall);
    logic [W:0]       expData = modelValue();
    logic [CNT_W-1:0] expCnt  = modelCount();
    nReadyArray = (stall == 0);
    for (int i = 0; i < digs.size(); i++)
      sendDigit(digs[i], i == digs.size() - 1);
    @(negedge clk);
    checkVal("conv_valid", 32'(validArray), 32'd0);
    checkVal("conv_ready", 32'(readyArray), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("out_valid", 32'(validArray), 32'd1);
    checkVal("out_data", 32'(dataOutArray), 32'(expData));
    checkVal("out_count", 32'(digitCount), 32'(expCnt));
    checkVal("out_ready", 32'(readyArray), 32'd0);
    $display("stream len=%0d stall=%0d data=%h count=%0d expected data=%h count=%0d",
             digs.size(), stall, dataOutArray, digitCount, expData, expCnt);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkVal("stall_valid", 32'(validArray), 32'd1);
      checkVal("stall_data", 32'(dataOutArray), 32'(expData));
      checkVal("stall_count", 32'(digitCount), 32'(expCnt));
      checkVal("stall_ready", 32'(readyArray), 32'd0);
    end
    nReadyArray = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("post_valid", 32'(validArray), 32'd0);
    checkVal("post_ready", 32'(readyArray), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rstn = 1'b0; pValidArray = 1'b0; nReadyArray = 1'b0;
    dataInArray = 2'b00; lastIn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkVal("rst_ready", 32'(readyArray), 32'd0);
    checkVal("rst_valid", 32'(validArray), 32'd0);
    checkVal("rst_data", 32'(dataOutArray), 32'd0);
    checkVal("rst_count", 32'(digitCount), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("idle_ready", 32'(readyArray), 32'd1);
    @(posedge clk); #1;

    digs = '{2'b10, 2'b00, 2'b01, 2'b10};
    runStream(0);
    checkVal("dir_0p4375", 32'(modelValue()), 32'h070);

    digs = {};
    repeat (8) digs.push_back(2'b01);
    runStream(0);

    digs = {};
    repeat (10) digs.push_back(2'b10);
    runStream(0);

    digs = '{2'b11};
    runStream(0);

    digs = '{2'b10, 2'b10, 2'b01};
    runStream(5);

    // Abort a stream after three digits; nothing must emerge from it.
    sendDigit(2'b10, 1'b0);
    sendDigit(2'b01, 1'b0);
    sendDigit(2'b10, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checkVal("abort_valid", 32'(validArray), 32'd0);
    checkVal("abort_data", 32'(dataOutArray), 32'd0);
    checkVal("abort_count", 32'(digitCount), 32'd0);
    checkVal("abort_ready", 32'(readyArray), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    digs = '{2'b10};
    runStream(0);

    // Saturation of the digit counter.
    digs = {};
    repeat (300) digs.push_back(2'($urandom));
    runStream(1);

    for (int t = 0; t < 25; t++) begin
      digs = {};
      repeat ($urandom_range(1, 12)) digs.push_back(2'($urandom));
      runStream($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
